// File: rtl/inv_drv_arbiter_pkg.sv
// rtl/inv_drv_arbiter_pkg.sv - state encodings and default sizing for the driver arbiter
package inv_drv_arbiter_pkg;

  // Encodings are fixed so waveforms and the bench agree on raw state values
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker starting at ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;
  logic          found;

  // Walk ptr, ptr+1, ... modulo N and take the first set request
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/inv_drv_arbiter.sv
// rtl/inv_drv_arbiter.sv - round-robin owner arbiter for a shared tristate bus driver
module inv_drv_arbiter
  import inv_drv_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic                 drv_en,
  output logic                 busy
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] ptr_after_owner;
  logic          drv_q, drv_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_req;
  logic          others_req;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // gnt_q is onehot(owner) during ARM/DRIVE, so masking req with it isolates the owner
  assign owner_req       = |(req & gnt_q);
  assign others_req      = |(req & ~gnt_q);
  assign ptr_after_owner = (sel_q == PW'(N - 1)) ? '0 : sel_q + PW'(1);

  // Next-state and next-output logic; outputs are registered alongside the state
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    drv_d   = drv_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, GAP: begin
        gnt_d  = '0;
        drv_d  = 1'b0;
        hold_d = '0;
        if (pick_any) begin
          state_d = ARM;
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        hold_d = '0;
        if (owner_req) begin
          state_d = DRIVE;
          drv_d   = 1'b1;
        end else begin
          state_d = GAP;
          gnt_d   = '0;
          drv_d   = 1'b0;
          ptr_d   = ptr_after_owner;
        end
      end
      DRIVE: begin
        if (!owner_req || (hold_q == HOLD_LAST && others_req)) begin
          state_d = GAP;
          gnt_d   = '0;
          drv_d   = 1'b0;
          hold_d  = '0;
          ptr_d   = ptr_after_owner;
        end else begin
          hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        drv_d   = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State, pointer, tenure counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      drv_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      drv_q   <= drv_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign drv_en = drv_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_inv_drv_arbiter.sv
// tb/tb_inv_drv_arbiter.sv - scoreboard bench for inv_drv_arbiter
module tb_inv_drv_arbiter;
  import inv_drv_arbiter_pkg::*;

  localparam int N  = DEF_N;
  localparam int MH = DEF_MAX_HOLD;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   sel;
  logic         drv_en;
  logic         busy;

  inv_drv_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .drv_en (drv_en),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic [1:0]   s;
    logic         d;
    logic         b;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;
  logic [N-1:0] prev_gnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // One cycle of stimulus plus the outputs expected after the following edge
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g,
                      input int s, input logic d, input logic b, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.g = g;
    e.s = 2'(s);
    e.d = d;
    e.b = b;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: pop one expectation per edge and check bus-safety invariants every cycle
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, " gnt"},    32'(gnt),    32'(e.g));
        chk({e.name, " sel"},    32'(sel),    32'(e.s));
        chk({e.name, " drv_en"}, 32'(drv_en), 32'(e.d));
        chk({e.name, " busy"},   32'(busy),   32'(e.b));
      end
      ok = $onehot0(gnt) && !(drv_en && gnt == '0) &&
           !(gnt != '0 && prev_gnt != '0 && gnt != prev_gnt);
      chk("invariant", 32'(ok), 32'd1);
      prev_gnt = gnt;
    end
  end

  initial begin
    int order[5];
    int o;
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0;

    step(1, 4'b0000, 4'b0000, 0, 0, 0, "reset0");
    step(1, 4'b0000, 4'b0000, 0, 0, 0, "reset1");

    step(0, 4'b0100, 4'b0100, 2, 0, 1, "single arm");
    step(0, 4'b0100, 4'b0100, 2, 1, 1, "single drive");
    step(0, 4'b0100, 4'b0100, 2, 1, 1, "single drive2");
    step(0, 4'b0000, 4'b0000, 2, 0, 1, "single gap");
    step(0, 4'b0000, 4'b0000, 2, 0, 0, "single idle");

    step(0, 4'b0010, 4'b0010, 1, 0, 1, "abort arm");
    step(0, 4'b0000, 4'b0000, 1, 0, 1, "abort gap");
    step(0, 4'b0000, 4'b0000, 1, 0, 0, "abort idle");

    step(0, 4'b1000, 4'b1000, 3, 0, 1, "rstsel arm");
    repeat (4) step(0, 4'b1000, 4'b1000, 3, 1, 1, "rstsel drive");
    step(1, 4'b1000, 4'b0000, 0, 0, 0, "rstsel reset");
    step(0, 4'b1010, 4'b0010, 1, 0, 1, "rstsel ptr0 arm");
    step(0, 4'b0000, 4'b0000, 1, 0, 1, "rstsel gap");
    step(0, 4'b0000, 4'b0000, 1, 0, 0, "rstsel idle");

    step(0, 4'b0001, 4'b0001, 0, 0, 1, "hold arm");
    repeat (29) step(0, 4'b0001, 4'b0001, 0, 1, 1, "hold drive");
    step(0, 4'b0000, 4'b0000, 0, 0, 1, "hold gap");
    step(0, 4'b0000, 4'b0000, 0, 0, 0, "hold idle");

    step(0, 4'b0001, 4'b0001, 0, 0, 1, "middrv arm");
    repeat (4) step(0, 4'b0001, 4'b0001, 0, 1, 1, "middrv drive");
    step(1, 4'b0001, 4'b0000, 0, 0, 0, "middrv reset");
    step(0, 4'b0001, 4'b0001, 0, 0, 1, "middrv regrant");
    step(0, 4'b0001, 4'b0001, 0, 1, 1, "middrv drive2");
    step(0, 4'b0000, 4'b0000, 0, 0, 1, "middrv gap");
    step(0, 4'b0000, 4'b0000, 0, 0, 0, "middrv idle");

    step(1, 4'b0000, 4'b0000, 0, 0, 0, "rr reset");
    for (int i = 0; i < 5; i++) begin
      o = order[i];
      step(0, 4'b1111, 4'(1 << o), o, 0, 1, "rr arm");
      repeat (MH) step(0, 4'b1111, 4'(1 << o), o, 1, 1, "rr drive");
      step(0, 4'b1111, 4'b0000, o, 0, 1, "rr gap");
    end
    step(0, 4'b0000, 4'b0000, 0, 0, 0, "rr idle");

    @(posedge clk);
    #2;
    chk("scoreboard drain", 32'(exp_q.size()), 32'd0);

    repeat (10000) begin
      @(negedge clk);
      req = N'($urandom_range(0, (1 << N) - 1));
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
